// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM encodings, recoding
// constants and step-count helpers. BOOTH_RADIX4_EN selects modified (radix-4) Booth.
package booth_pkg;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Radix-2 recoding of {Qr[0], q_m1}
  localparam logic [1:0] B_01 = 2'b01;
  localparam logic [1:0] B_10 = 2'b10;

  // Radix-4 recoding of {Qr[1], Qr[0], q_m1}
  localparam logic [2:0] R4_P1A = 3'b001;
  localparam logic [2:0] R4_P1B = 3'b010;
  localparam logic [2:0] R4_P2  = 3'b011;
  localparam logic [2:0] R4_M2  = 3'b100;
  localparam logic [2:0] R4_M1A = 3'b101;
  localparam logic [2:0] R4_M1B = 3'b110;

`ifdef BOOTH_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif

  function automatic int booth_steps(input int width_q, input bit radix4);
    return radix4 ? (width_q + 1) / 2 : width_q;
  endfunction

  // Radix-4 consumes two multiplier bits per step, so Qr is padded to an even width.
  function automatic int booth_qr_width(input int width_q, input bit radix4);
    return radix4 ? width_q + (width_q % 2) : width_q;
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Start/done handshake and operand/product bus of the sequential Booth multiplier.
interface booth_seq_multiplier_if #(
    parameter int WIDTH_M = 5,
    parameter int WIDTH_Q = 5
);
    logic                              start;
    logic signed [WIDTH_M-1:0]         multiplicand;
    logic signed [WIDTH_Q-1:0]         multiplier;
    logic                              busy;
    logic                              done;
    logic signed [WIDTH_M+WIDTH_Q-1:0] product;

    modport master (output start, multiplicand, multiplier, input busy, done, product);
    modport slave  (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/booth_step.sv
// One combinational Booth add/subtract-and-shift step on {A, Qr, q_m1}.
// BOOTH_RADIX4_EN selects the radix-4 recoding with a 2-bit arithmetic shift.
module booth_step
    import booth_pkg::*;
#(
    parameter int WA  = 7,
    parameter int WQR = 5
) (
    input  logic signed [WA-1:0]  a,
    input  logic        [WQR-1:0] qr,
    input  logic                  q_m1,
    input  logic signed [WA-1:0]  m,
    output logic signed [WA-1:0]  a_nxt,
    output logic        [WQR-1:0] qr_nxt,
    output logic                  q_m1_nxt
);

    logic signed [WA-1:0] sum;

`ifdef BOOTH_RADIX4_EN
    // NOTE: sum gets a default before the case so this always_comb never infers a latch.
    always_comb begin
        sum = a;
        case ({qr[1:0], q_m1})
            R4_P1A, R4_P1B: sum = a + m;
            R4_P2:          sum = a + (m <<< 1);
            R4_M2:          sum = a - (m <<< 1);
            R4_M1A, R4_M1B: sum = a - m;
            default:        sum = a;
        endcase
    end

    assign {a_nxt, qr_nxt, q_m1_nxt} = {{2{sum[WA-1]}}, sum, qr[WQR-1:1]};
`else
    // NOTE: sum gets a default before the case so this always_comb never infers a latch.
    always_comb begin
        sum = a;
        case ({qr[0], q_m1})
            B_01:    sum = a + m;
            B_10:    sum = a - m;
            default: sum = a;
        endcase
    end

    assign {a_nxt, qr_nxt, q_m1_nxt} = {sum[WA-1], sum, qr};
`endif

endmodule

// File: rtl/booth_seq_multiplier.sv
// Signed sequential Booth multiplier: operand capture, step FSM and registered product.
// Define BOOTH_RADIX4_EN for radix-4 operation (about half the steps).
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH_M = 5,
    parameter int WIDTH_Q = 5
) (
    input logic clk,
    input logic rst,
    booth_seq_multiplier_if.slave bus
);

    localparam int N  = booth_steps(WIDTH_Q, RADIX4);
    localparam int QW = booth_qr_width(WIDTH_Q, RADIX4);
    localparam int WA = WIDTH_M + 2;
    localparam int PW = WIDTH_M + WIDTH_Q;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic signed [WA-1:0]   a;
    logic signed [WA-1:0]   m_reg;
    logic        [QW-1:0]   qr;
    logic                   q_m1;
    logic signed [WA-1:0]   a_nxt;
    logic        [QW-1:0]   qr_nxt;
    logic                   q_m1_nxt;
    logic signed [PW-1:0]   product_q;
    logic                   done_q;

    booth_step #(.WA(WA), .WQR(QW)) u_step (
        .a        (a),
        .qr       (qr),
        .q_m1     (q_m1),
        .m        (m_reg),
        .a_nxt    (a_nxt),
        .qr_nxt   (qr_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: working registers are cleared as well, so an aborted multiply leaves no trace.
            state     <= S_IDLE;
            cnt       <= '0;
            a         <= '0;
            m_reg     <= '0;
            qr        <= '0;
            q_m1      <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a     <= '0;
                        qr    <= QW'(bus.multiplier);
                        q_m1  <= 1'b0;
                        m_reg <= WA'(bus.multiplicand);
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    a    <= a_nxt;
                    qr   <= qr_nxt;
                    q_m1 <= q_m1_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    // The result is exact, so the low bits of {A, Qr} are the full product.
                    product_q <= PW'({a, qr});
                    done_q    <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // busy also covers the cycle in which the done pulse is presented.
    assign bus.busy    = (state != S_IDLE) || done_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench: directed vector table at 5x5 plus handshake corner cases,
// and a signed sweep on an 8x7 instance; honours BOOTH_RADIX4_EN for cycle counts.
module tb_booth_seq_multiplier;

    localparam int WM  = 5;
    localparam int WQ  = 5;
    localparam int WM2 = 8;
    localparam int WQ2 = 7;
`ifdef BOOTH_RADIX4_EN
    localparam int N  = 3;
    localparam int N2 = 4;
`else
    localparam int N  = 5;
    localparam int N2 = 7;
`endif

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_seq_multiplier_if #(.WIDTH_M(WM),  .WIDTH_Q(WQ))  bus  ();
    booth_seq_multiplier_if #(.WIDTH_M(WM2), .WIDTH_Q(WQ2)) bus2 ();

    booth_seq_multiplier #(.WIDTH_M(WM), .WIDTH_Q(WQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    booth_seq_multiplier #(.WIDTH_M(WM2), .WIDTH_Q(WQ2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic signed [4:0] m;
        logic signed [4:0] q;
        logic signed [9:0] p;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete multiply on the 5x5 instance with start pulsed for a single cycle.
    task automatic run_op(input logic signed [4:0] m, input logic signed [4:0] q,
                          input logic signed [9:0] exp, input string name);
        bit seen;
        int lat;
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.multiplicand = ~m;
        bus.multiplier   = ~q;
        check({name, "_busy_rise"}, bus.busy, 1);
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= N + 4 && !seen; k++) begin
            tick();
            if (bus.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({name, "_latency"}, lat, N + 1);
        check({name, "_product"}, bus.product, exp);
        tick();
        check({name, "_done_one_cycle"}, bus.done, 0);
        check({name, "_busy_fall"}, bus.busy, 0);
        check({name, "_product_held"}, bus.product, exp);
    endtask

    task automatic run2(input logic signed [7:0] m, input logic signed [6:0] q);
        int ref_p;
        bit seen;
        int lat;
        ref_p = int'(m) * int'(q);
        bus2.multiplicand = m;
        bus2.multiplier   = q;
        bus2.start        = 1'b1;
        tick();
        bus2.start = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= N2 + 4 && !seen; k++) begin
            tick();
            if (bus2.done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check("w87_latency", lat, N2 + 1);
        check($sformatf("w87_product %0d*%0d", m, q), bus2.product, ref_p);
        tick();
    endtask

    initial begin
        logic signed [4:0] bb_m [4];
        logic signed [4:0] bb_q [4];
        logic signed [9:0] bb_p [4];
        int                n_done;
        logic signed [9:0] cap_p;
        logic [31:0]       r;

        vecs[0] = '{m: 5'sh07, q: 5'sh1D, p: 10'sh3EB};  //   7 *  -3 =  -21
        vecs[1] = '{m: 5'sh10, q: 5'sh10, p: 10'sh100};  // -16 * -16 =  256
        vecs[2] = '{m: 5'sh10, q: 5'sh0F, p: 10'sh310};  // -16 *  15 = -240
        vecs[3] = '{m: 5'sh0F, q: 5'sh10, p: 10'sh310};  //  15 * -16 = -240
        vecs[4] = '{m: 5'sh10, q: 5'sh01, p: 10'sh3F0};  // -16 *   1 =  -16
        vecs[5] = '{m: 5'sh05, q: 5'sh10, p: 10'sh3B0};  //   5 * -16 =  -80
        vecs[6] = '{m: 5'sh1F, q: 5'sh0F, p: 10'sh3F1};  //  -1 *  15 =  -15
        vecs[7] = '{m: 5'sh00, q: 5'sh10, p: 10'sh000};  //   0 * -16 =    0
        vecs[8] = '{m: 5'sh0F, q: 5'sh0F, p: 10'sh0E1};  //  15 *  15 =  225
        vecs[9] = '{m: 5'sh19, q: 5'sh06, p: 10'sh3D6};  //  -7 *   6 =  -42

        bb_m = '{5'sh00, 5'sh01, 5'sh1F, 5'sh0F};
        bb_q = '{5'sh05, 5'sh1F, 5'sh1F, 5'sh0F};
        bb_p = '{10'sh000, 10'sh3FF, 10'sh001, 10'sh0E1};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        bus2.start = 1'b0;
        bus2.multiplicand = '0;
        bus2.multiplier = '0;
        tick();
        tick();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_product", bus.product, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].m, vecs[i].q, vecs[i].p, $sformatf("vec%0d", i));

        // start pulsed again during CALC with other operands must be ignored
        bus.multiplicand = 5'sh07;
        bus.multiplier   = 5'sh1D;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.multiplicand = 5'sh03;
        bus.multiplier   = 5'sh03;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        n_done = 0;
        cap_p  = '0;
        for (int k = 0; k < 2 * N + 6; k++) begin
            tick();
            if (bus.done) begin
                n_done++;
                cap_p = bus.product;
            end
        end
        check("calc_start_done_count", n_done, 1);
        check("calc_start_product", cap_p, -21);
        check("calc_start_idle", bus.busy, 0);

        // reset in the third CALC cycle discards the partial result
        bus.multiplicand = 5'sh05;
        bus.multiplier   = 5'sh05;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midcalc_rst_busy", bus.busy, 0);
        check("midcalc_rst_done", bus.done, 0);
        check("midcalc_rst_product", bus.product, 0);
        bus.start = 1'b1;
        bus.multiplicand = 5'sh03;
        bus.multiplier   = 5'sh03;
        tick();
        check("rst_start_busy", bus.busy, 0);
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        check("rst_start_dropped", bus.busy, 0);
        check("rst_start_product", bus.product, 0);
        run_op(5'sh07, 5'sh1D, 10'sh3EB, "after_rst");

        // start held high: back-to-back operations every N+2 cycles
        bus.multiplicand = bb_m[0];
        bus.multiplier   = bb_q[0];
        bus.start        = 1'b1;
        tick();
        for (int c = 0; c <= 4 * (N + 2); c++) begin
            if ((c % (N + 2)) == 0 && (c / (N + 2)) <= 2) begin
                bus.multiplicand = bb_m[c / (N + 2) + 1];
                bus.multiplier   = bb_q[c / (N + 2) + 1];
            end
            if (c == 3 * (N + 2)) bus.start = 1'b0;
            if ((c % (N + 2)) == N + 1) begin
                check($sformatf("b2b_done_c%0d", c), bus.done, 1);
                check($sformatf("b2b_product%0d", c / (N + 2)), bus.product, bb_p[c / (N + 2)]);
            end else begin
                check($sformatf("b2b_done_c%0d", c), bus.done, 0);
            end
            tick();
        end
        check("b2b_busy_end", bus.busy, 0);

        // wider instance: corners plus random signed operands
        run2(8'sh80, 7'sh40);
        run2(8'sh80, 7'sh3F);
        run2(8'sh7F, 7'sh3F);
        run2(8'sh7F, 7'sh40);
        run2(8'shFF, 7'sh7F);
        run2(8'sh00, 7'sh55);
        for (int i = 0; i < 30; i++) begin
            r = $urandom;
            run2(r[7:0], r[14:8]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
